// File: rtl/regfile_scoreboard.sv
// Two-write-port register file with write-back bypass and a per-register pending-write
// scoreboard. A clear sequencer zeroes the array one entry per cycle after reset or clear_req.
module regfile_scoreboard #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned AW       = 5,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear_req,
  output logic            ready,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  output logic            busy1,
  output logic            busy2,
  input  logic            WE_A,
  input  logic [AW-1:0]   A3,
  input  logic [XLEN-1:0] WD3,
  input  logic            WE_B,
  input  logic [AW-1:0]   A4,
  input  logic [XLEN-1:0] WD4,
  input  logic            set_busy,
  input  logic [AW-1:0]   busy_addr
);

  localparam int unsigned NREGS = 1 << AW;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [XLEN-1:0]   mem_q [NREGS];

  logic run;
  logic we_a_eff;
  logic we_b_eff;
  logic set_eff;

  assign run   = (state_q == StRun);
  assign ready = run;

  // Writes to a hardwired-zero entry are dropped entirely, including from the bypass path.
  assign we_a_eff = run && WE_A && !(ZERO_REG && (A3 == '0));
  assign we_b_eff = run && WE_B && !(ZERO_REG && (A4 == '0));
  assign set_eff  = run && set_busy && !(ZERO_REG && (busy_addr == '0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StInit: begin
        if (clear_req) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == {AW{1'b1}}) begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (clear_req) begin
          state_d = StInit;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StInit;
        cnt_d   = '0;
      end
    endcase
  end

  // Set beats clear on the same address: the new producer owns the register.
  always_comb begin
    busy_d = busy_q;
    if (!run || clear_req) begin
      busy_d = '0;
    end else begin
      if (we_b_eff) begin
        busy_d[A4] = 1'b0;
      end
      if (set_eff) begin
        busy_d[busy_addr] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StInit;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Array has no reset; the sequencer zeroes it. Port B is applied last so it wins.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem_q[cnt_q] <= '0;
    end else begin
      if (we_a_eff) begin
        mem_q[A3] <= WD3;
      end
      if (we_b_eff) begin
        mem_q[A4] <= WD4;
      end
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0]   addr,
                                                input logic [XLEN-1:0] stored);
    logic [XLEN-1:0] data;
    if (!run || (ZERO_REG && (addr == '0))) begin
      data = '0;
    end else if (we_b_eff && (A4 == addr)) begin
      data = WD4;
    end else if (we_a_eff && (A3 == addr)) begin
      data = WD3;
    end else begin
      data = stored;
    end
    return data;
  endfunction

  assign RD1 = read_port(A1, mem_q[A1]);
  assign RD2 = read_port(A2, mem_q[A2]);

  // A same-cycle port-B write-back satisfies the waiting consumer.
  assign busy1 = run && busy_q[A1] && !(we_b_eff && (A4 == A1));
  assign busy2 = run && busy_q[A2] && !(we_b_eff && (A4 == A2));

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: one instance with a hardwired zero entry, one without,
// sharing all inputs.
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        clear_req;
  logic [4:0]  A1, A2, A3, A4, busy_addr;
  logic [31:0] WD3, WD4;
  logic        WE_A, WE_B, set_busy;

  logic        ready, busy1, busy2;
  logic [31:0] RD1, RD2;
  logic        ready0, busy1_0, busy2_0;
  logic [31:0] RD1_0, RD2_0;

  int nchk  = 0;
  int npass = 0;
  int n;

  regfile_scoreboard #(.XLEN(32), .AW(5), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(ready),
    .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2), .busy1(busy1), .busy2(busy2),
    .WE_A(WE_A), .A3(A3), .WD3(WD3), .WE_B(WE_B), .A4(A4), .WD4(WD4),
    .set_busy(set_busy), .busy_addr(busy_addr)
  );

  regfile_scoreboard #(.XLEN(32), .AW(5), .ZERO_REG(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(ready0),
    .A1(A1), .A2(A2), .RD1(RD1_0), .RD2(RD2_0), .busy1(busy1_0), .busy2(busy2_0),
    .WE_A(WE_A), .A3(A3), .WD3(WD3), .WE_B(WE_B), .A4(A4), .WD4(WD4),
    .set_busy(set_busy), .busy_addr(busy_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    WE_A = 1'b0; WE_B = 1'b0; set_busy = 1'b0; clear_req = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    n = 0;
    while (!ready && n < 100) begin
      step();
      n++;
    end
    chk(tag, n, 32);
  endtask

  initial begin
    rst_n = 1'b0; clear_req = 1'b0;
    A1 = '0; A2 = '0; A3 = '0; A4 = '0; busy_addr = '0;
    WD3 = '0; WD4 = '0; WE_A = 1'b0; WE_B = 1'b0; set_busy = 1'b0;

    // 1: reset and clear sequence
    #12;
    chk("reset_ready", ready, 0);
    chk("reset_busy1", busy1, 0);
    #10 rst_n = 1'b1;
    wait_ready("init_len");
    chk("init_ready0", ready0, 1);
    for (int a = 0; a < 32; a++) begin
      A1 = a[4:0];
      #1;
      chk($sformatf("cleared_%0d", a), RD1, 0);
    end

    // 2: same-address dual write, port B wins in bypass and in array
    WE_A = 1'b1; A3 = 5; WD3 = 32'h11;
    WE_B = 1'b1; A4 = 5; WD4 = 32'h22; A1 = 5;
    #1;
    chk("dual_bypass", RD1, 32'h22);
    step(); idle_inputs(); #1;
    chk("dual_array", RD1, 32'h22);

    // port A alone: bypass then array
    WE_A = 1'b1; A3 = 9; WD3 = 32'h99; A2 = 9;
    #1;
    chk("porta_bypass", RD2, 32'h99);
    step(); idle_inputs(); #1;
    chk("porta_array", RD2, 32'h99);

    // 3: address 0, zero reg vs ordinary entry
    WE_A = 1'b1; A3 = 0; WD3 = 32'hFFFF_FFFF; A1 = 0; set_busy = 1'b1; busy_addr = 0;
    #1;
    chk("z_rd_now", RD1, 0);
    chk("z_busy_now", busy1, 0);
    chk("nz_rd_now", RD1_0, 32'hFFFF_FFFF);
    chk("nz_busy_now", busy1_0, 0);
    step(); idle_inputs(); #1;
    chk("z_rd_next", RD1, 0);
    chk("z_busy_next", busy1, 0);
    chk("nz_rd_next", RD1_0, 32'hFFFF_FFFF);
    chk("nz_busy_next", busy1_0, 1);

    // 4: scoreboard set / clear / set-wins
    set_busy = 1'b1; busy_addr = 7; A1 = 7; A2 = 7;
    #1;
    chk("sb_not_yet", busy1, 0);
    step(); idle_inputs(); #1;
    chk("sb_set", busy1, 1);
    chk("sb_set_p2", busy2, 1);
    WE_B = 1'b1; A4 = 7; WD4 = 32'h55;
    #1;
    chk("sb_bypass_busy", busy1, 0);
    chk("sb_bypass_rd", RD1, 32'h55);
    step(); idle_inputs(); #1;
    chk("sb_cleared", busy1, 0);
    chk("sb_rd_array", RD1, 32'h55);
    set_busy = 1'b1; busy_addr = 7;
    step(); idle_inputs(); #1;
    chk("sb_reset_again", busy1, 1);
    set_busy = 1'b1; busy_addr = 7; WE_B = 1'b1; A4 = 7; WD4 = 32'h66;
    #1;
    chk("sb_both_now", busy2, 0);
    step(); idle_inputs(); #1;
    chk("sb_set_wins", busy1, 1);
    chk("sb_set_wins_rd", RD1, 32'h66);
    // port A write does not clear busy
    WE_A = 1'b1; A3 = 7; WD3 = 32'h77;
    step(); idle_inputs(); #1;
    chk("porta_keeps_busy", busy1, 1);
    chk("porta_rd", RD1, 32'h77);

    // 5: clear_req in RUN
    set_busy = 1'b1; busy_addr = 3; WE_A = 1'b1; A3 = 3; WD3 = 32'h33; A1 = 3;
    step(); idle_inputs(); #1;
    chk("pre_clr_busy", busy1, 1);
    chk("pre_clr_rd", RD1, 32'h33);
    clear_req = 1'b1;
    step(); idle_inputs(); #1;
    chk("clr_ready", ready, 0);
    chk("clr_busy", busy1, 0);
    chk("clr_rd", RD1, 0);
    WE_A = 1'b1; A3 = 3; WD3 = 32'hAA;
    wait_ready("clr_len");
    WE_A = 1'b0;
    #1;
    chk("clr_reg3", RD1, 0);
    chk("clr_busy_after", busy1, 0);
    A1 = 7;
    #1;
    chk("clr_reg7", RD1, 0);

    // 6: reset pulse mid-INIT
    rst_n = 1'b0; #2 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("mid_init_ready", ready, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", ready, 0);
    #1 rst_n = 1'b1;
    wait_ready("rst_restart_len");
    chk("rst_ready0", ready0, 1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the integer/float register file: configurable data width and depth, two write ports, and a per-register pending-write scoreboard.
- Adds a post-reset clear sequencer that zeroes the array one entry per cycle; ready is held low until the clear completes.
- Sits in decode/writeback. Port A carries ALU writeback; port B carries late (load/FPU) writeback.
- Decode stalls on the busy outputs.

Parameters:
- XLEN, 32, data width of each register.
- AW, 5, address width; depth NREGS = 2**AW.
- ZERO_REG, 1, 1: entry 0 is hardwired zero, never written, never busy. 0: entry 0 behaves like any other entry.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear_req  in  1  restarts the clear sequence (e.g. FP context reset).
- ready  out  1  1 when the array is usable (FSM in RUN).
- A1, A2  in  AW  read addresses.
- RD1, RD2  out  XLEN  read data (combinational).
- busy1, busy2  out  1  pending-write flag for A1 / A2 (combinational).
- WE_A  in  1  write enable, port A.
- A3  in  AW  write address, port A.
- WD3  in  XLEN  write data, port A.
- WE_B  in  1  write enable, port B.
- A4  in  AW  write address, port B.
- WD4  in  XLEN  write data, port B.
- set_busy  in  1  mark a register as having a pending port-B write.
- busy_addr  in  AW  register to mark.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FSM goes to INIT, clear counter to 0, all busy bits to 0, ready=0.
  - The register array itself is not reset.
- FSM states:
  - INIT: writes 0 to entry[counter] each cycle, then increments counter. When counter=NREGS-1 is written, moves to RUN on the same edge. ready=1 from the first RUN cycle; INIT lasts exactly NREGS cycles after reset release.
  - RUN: normal operation. clear_req=1 moves to INIT with counter=0, and all busy bits clear on that edge.
  - clear_req in INIT restarts counter at 0.
- During INIT:
  - WE_A, WE_B and set_busy are ignored.
  - RD1/RD2 read 0 and busy1/busy2 read 0.
- Writes (RUN):
  - Synchronous. Port A writes WD3 to A3 when WE_A; port B writes WD4 to A4 when WE_B.
  - Same address on both ports in the same cycle: port B wins.
  - ZERO_REG=1: writes to address 0 are dropped on both ports.
- Reads (combinational, RUN):
  - ZERO_REG=1 and addr=0 gives 0.
  - Otherwise, if WE_B and A4==addr, returns WD4.
  - Otherwise, if WE_A and A3==addr, returns WD3.
  - Otherwise returns the stored entry.
  - Bypass never applies to a write that is dropped (address 0 with ZERO_REG=1).
- Scoreboard (RUN):
  - set_busy sets busy[busy_addr] at the next edge.
  - WE_B clears busy[A4] at the next edge.
  - Set and clear on the same address in the same cycle: set wins (the new producer owns the register).
  - Port A never touches busy bits.
  - ZERO_REG=1: busy[0] is never set.
  - busy1 = busy[A1], forced to 0 when WE_B and A4==A1 in the same cycle (the write-back bypass satisfies the consumer); busy2 is the same rule for A2.
  - clear_req or reset clears all busy bits.
- No other latency: write-to-read is 0 cycles via bypass and 1 cycle via the array.

Test Plan:
1. Reset release, no writes, then RUN: ready=0 for exactly 32 cycles and rises on cycle 33. Afterwards RD1 reads 0 for every address, including entries first preloaded with X or 0xDEADBEEF via hierarchical force before reset.
2. RUN, WE_A=1, A3=5, WD3=0x11, and in the same cycle WE_B=1, A4=5, WD4=0x22, A1=5: RD1=0x22 in that cycle. Next cycle, with no writes, RD1=0x22.
3. ZERO_REG=1, WE_A=1, A3=0, WD3=0xFFFF_FFFF, A1=0, and set_busy=1, busy_addr=0: RD1=0 and busy1=0, both in that cycle and the next. Repeat with ZERO_REG=0: RD1 bypasses 0xFFFF_FFFF, and busy1=1 the next cycle.
4. set_busy with busy_addr=7: busy1=1 when A1=7 from the next cycle. WE_B with A4=7, WD4=0x55: busy1=0 and RD1=0x55 in the same cycle. Then set_busy=1 with busy_addr=7 together with WE_B to A4=7: busy stays 1.
5. In RUN with busy[3]=1, assert clear_req for 1 cycle: ready=0 next cycle, busy1(A1=3)=0, WE_A writes are ignored for 32 cycles, and register 3 reads 0 afterwards.
6. rst_n pulsed low mid-INIT at counter=10: ready stays 0, the counter restarts, and ready rises 32 cycles after the reset release.
